pll_reset_sequencer: RTL
========================

Name: pll_reset_sequencer

Overview:
Controls the reset/locked interface of a clock-generator PLL from the PLL's side of the fabric. Runs on the 50 MHz reference clock and drives the PLL reset pulse. Watches the PLL lock output, retries on lock timeout and holds the system reset until lock has been stable for a set time. Detects loss of lock during operation and re-sequences; raises a sticky fault after too many failed attempts.

Parameters:
PLL_RST_CYCLES, 16, width of each pll_rst pulse in refclk cycles (>=1)
LOCK_TIMEOUT, 50000, refclk cycles allowed in WAIT_LOCK before a retry (1 ms at 50 MHz)
LOCK_STABLE_CYCLES, 1024, consecutive synchronized-locked cycles required before release
MAX_RETRIES, 7, timeouts tolerated before FAULT; retry_count width 3
SYNC_STAGES, 2, flops in the pll_locked synchronizer (>=2)
LOSS_FILTER_CYCLES, 4, consecutive low samples declaring loss of lock (only with the optional feature)

Ports:
refclk  in  1  sole clock, 50 MHz reference
rst  in  1  synchronous, active-high reset
pll_locked  in  1  PLL lock flag, asynchronous to refclk
pll_rst  out  1  reset to the PLL
sys_rst  out  1  reset to logic clocked by PLL outputs, active high
ready  out  1  high while in RUN
retry_count  out  3  timeouts since last RUN entry or rst
fault  out  1  sticky; PLL failed to lock MAX_RETRIES+1 times
lock_lost  out  1  one-cycle pulse on loss of lock in RUN

Behaviour:
- Single refclk domain. The only async input, pll_locked, passes through a SYNC_STAGES flop chain to give locked_s. Chain clears to 0 on rst.
- States: RESET_PLL, WAIT_LOCK, STABILIZE, RUN, FAULT. One shared counter is cleared on every state entry.
- Outputs are Moore, registered, and decoded from state. They change on the edge that enters a state.
- rst=1 (any state, mid-operation included): next edge gives state RESET_PLL, counter=0, retry_count=0, pll_rst=1, sys_rst=1, ready=0, fault=0, lock_lost=0.
- RESET_PLL: pll_rst=1, sys_rst=1. Stays exactly PLL_RST_CYCLES cycles, then goes to WAIT_LOCK.
- WAIT_LOCK: pll_rst=0, sys_rst=1.
  - locked_s=1 -> STABILIZE.
  - Counter reaches LOCK_TIMEOUT-1 with locked_s=0, and retry_count<MAX_RETRIES -> retry_count+1, go to RESET_PLL.
  - Same timeout with retry_count==MAX_RETRIES -> FAULT; retry_count holds at MAX_RETRIES.
  - Lock and timeout on the same cycle: lock wins.
- STABILIZE: pll_rst=0, sys_rst=1. Counter increments while locked_s=1.
  - locked_s=0 -> WAIT_LOCK, timeout restarted, no retry increment.
  - Counter == LOCK_STABLE_CYCLES-1 with locked_s=1 -> RUN, giving exactly LOCK_STABLE_CYCLES cycles in STABILIZE.
- RUN: sys_rst=0, ready=1, retry_count cleared on entry.
  - Loss of lock -> RESET_PLL and lock_lost=1 for that single cycle.
  - sys_rst=1 and ready=0 on the same edge.
- FAULT: pll_rst=0, sys_rst=1, ready=0, fault=1. Only rst exits.
- Latency: pll_locked rising edge to STABILIZE entry is SYNC_STAGES+1 edges. Rising edge to ready is SYNC_STAGES+1+LOCK_STABLE_CYCLES edges.
- Loss of lock (without the macro): one locked_s=0 sample in RUN.
- Counter width is sized by clog2 of the largest count parameter. No wrap is possible.

Optional Feature:
LOCK_GLITCH_FILTER_EN
- Defined: in RUN, loss is declared only after LOSS_FILTER_CYCLES consecutive locked_s=0 samples. A filter counter clears on any locked_s=1. Declaration latency after the synchronizer is LOSS_FILTER_CYCLES cycles.
- Not defined: a single low sample triggers loss, and no filter logic is built.
- WAIT_LOCK and STABILIZE behaviour is identical either way.

Test Plan:
Bench parameters: PLL_RST_CYCLES=16, LOCK_TIMEOUT=200, LOCK_STABLE_CYCLES=32, SYNC_STAGES=2, MAX_RETRIES=7.
1. Normal lock: release rst; raise pll_locked 50 cycles after pll_rst falls, hold it -> pll_rst high exactly 16 cycles; ready=1 and sys_rst=0 exactly 35 edges after pll_locked is sampled high; retry_count=0.
2. Timeout/fault: hold pll_locked=0 -> 8 pll_rst pulses of 16 cycles, spaced 200 cycles apart. retry_count steps 1..7, then fault=1 and sys_rst=1 permanently. Asserting rst clears fault.
3. Glitch in STABILIZE: pll_locked low for 3 cycles, 10 cycles into STABILIZE -> state returns to WAIT_LOCK, no retry increment. After re-lock, ready rises 35 edges after the new lock edge.
4. Loss in RUN: drop pll_locked for 1 cycle (macro off) -> lock_lost pulse of 1 cycle, sys_rst=1, ready=0, pll_rst=1 for 16 cycles. Full re-sequence follows to ready=1.
5. rst mid-WAIT_LOCK after 2 retries: assert rst 1 cycle -> next edge retry_count=0, pll_rst=1, sys_rst=1. A full 16-cycle pulse restarts.
6. LOCK_GLITCH_FILTER_EN defined: in RUN, a 3-cycle low on pll_locked -> ready stays 1, no lock_lost. A 4-cycle low -> lock_lost exactly once, RESET_PLL entered.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock sequencer on refclk; Moore outputs registered one edge after the decision, no backpressure.
// Optional `LOCK_GLITCH_FILTER_EN`: in RUN, loss needs LOSS_FILTER_CYCLES consecutive unlocked samples.
module pll_reset_sequencer #(
  parameter int PLL_RST_CYCLES     = 16,
  parameter int LOCK_TIMEOUT       = 50000,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES        = 7,
  parameter int SYNC_STAGES        = 2,
  parameter int LOSS_FILTER_CYCLES = 4
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic [2:0] retry_count,
  output logic       fault,
  output logic       lock_lost
);

  localparam int MAX_AB  = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_CD  = (LOCK_STABLE_CYCLES > LOSS_FILTER_CYCLES) ? LOCK_STABLE_CYCLES
                                                                      : LOSS_FILTER_CYCLES;
  localparam int MAX_CNT = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW      = $clog2(MAX_CNT + 1);

  localparam logic [CW-1:0] RST_LAST  = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STB_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [2:0]    RETRY_MAX = 3'(MAX_RETRIES);
`ifdef LOCK_GLITCH_FILTER_EN
  localparam logic [CW-1:0] FLT_LAST  = CW'(LOSS_FILTER_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    S_RESET_PLL,
    S_WAIT_LOCK,
    S_STABILIZE,
    S_RUN,
    S_FAULT
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [2:0]             retry_q, retry_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   pll_rst_q, pll_rst_d;
  logic                   sys_rst_q, sys_rst_d;
  logic                   ready_q, ready_d;
  logic                   fault_q, fault_d;
  logic                   lock_lost_q, lock_lost_d;
  logic                   locked_s;

  assign sync_d   = {sync_q[SYNC_STAGES-2:0], pll_locked};
  assign locked_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q     <= S_RESET_PLL;
      cnt_q       <= '0;
      retry_q     <= '0;
      sync_q      <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_q   <= 1'b1;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      sync_q      <= sync_d;
      pll_rst_q   <= pll_rst_d;
      sys_rst_q   <= sys_rst_d;
      ready_q     <= ready_d;
      fault_q     <= fault_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    retry_d = retry_q;
    case (state_q)
      S_RESET_PLL: begin
        if (cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        // Lock is tested first so it wins over a coincident timeout.
        if (locked_s) begin
          state_d = S_STABILIZE;
        end else if (cnt_q == TO_LAST) begin
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + 3'd1;
            state_d = S_RESET_PLL;
          end else begin
            state_d = S_FAULT;
          end
        end
      end
      S_STABILIZE: begin
        if (!locked_s)             state_d = S_WAIT_LOCK;
        else if (cnt_q == STB_LAST) state_d = S_RUN;
      end
      S_RUN: begin
`ifdef LOCK_GLITCH_FILTER_EN
        // Counter tracks the run of consecutive unlocked samples.
        cnt_d = locked_s ? '0 : cnt_q + 1'b1;
        if (!locked_s && cnt_q == FLT_LAST) state_d = S_RESET_PLL;
`else
        cnt_d = cnt_q;
        if (!locked_s) state_d = S_RESET_PLL;
`endif
      end
      S_FAULT: begin
        cnt_d = cnt_q;
      end
      default: begin
        state_d = S_RESET_PLL;
      end
    endcase
    if (state_d != state_q) cnt_d = '0;
    if (state_d == S_RUN && state_q != S_RUN) retry_d = '0;
  end

  always_comb begin
    pll_rst_d   = (state_d == S_RESET_PLL);
    sys_rst_d   = (state_d != S_RUN);
    ready_d     = (state_d == S_RUN);
    fault_d     = (state_d == S_FAULT);
    lock_lost_d = (state_q == S_RUN) && (state_d == S_RESET_PLL);
  end

  assign pll_rst     = pll_rst_q;
  assign sys_rst     = sys_rst_q;
  assign ready       = ready_q;
  assign retry_count = retry_q;
  assign fault       = fault_q;
  assign lock_lost   = lock_lost_q;

endmodule
